seq_div: RTL and testbench
==========================

# seq_div

Sequential radix-2 restoring divider, the inverse companion of the team's shift-add multiplier `mult`. It shares that block's `start`/`ready` handshake style and its clock/reset naming. It accepts a 32-bit dividend and divisor on a one-cycle `start` pulse and iterates one quotient bit per clock. It then presents quotient, remainder and a divide-by-zero flag. It sits beside `mult` in the bus-slave arithmetic datapath.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width.
- `SIGNED`, default 0: 0 selects unsigned division; 1 selects two's-complement division truncating toward zero.
- `clk`  in  1  clock; all state changes on the rising edge.
- `_rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  request pulse; sampled only when the unit is not busy.
- `a`  in  WIDTH  dividend; sampled on the accepting edge.
- `b`  in  WIDTH  divisor; sampled on the accepting edge.
- `quo`  out  WIDTH  quotient; valid while `ready`=1.
- `rem`  out  WIDTH  remainder; valid while `ready`=1.
- `ready`  out  1  result valid; held until the next accepted `start`.
- `dbz`  out  1  divide-by-zero; valid with `ready`.

## Operation
- States are IDLE, BUSY and DONE.
- Reset (`_rst`=0 at an edge) forces IDLE and clears all outputs: `quo`=0, `rem`=0, `ready`=0, `dbz`=0. Reset aborts any operation in progress; no partial result is kept.
- IDLE or DONE with `start`=1 leads to one of two paths:
  - Divisor nonzero: capture the operands, clear `ready`, `dbz` and `cnt`, and enter BUSY.
  - `b`==0: enter DONE on the next edge.
- Unsigned path: the internal working state is a partial remainder R (WIDTH+1 bits) and a shifting quotient register Q.
- Signed path: the magnitudes of `a` and `b` are captured. The quotient sign is `a[MSB]^b[MSB]` and the remainder sign is `a[MSB]`. Both signs are applied on the transition to DONE.
- Each BUSY cycle performs one restoring step:
  - R' = {R, Q[MSB]} − |b|.
  - If R' is non-negative, the new quotient bit is 1 and R' is kept. Otherwise the bit is 0 and the shifted R is kept.
  - Q shifts left, taking the new bit into its LSB.
  - `cnt` increments.
- After step WIDTH−1 (`cnt`==WIDTH−1), the step result is written to `quo`/`rem`, with sign correction in signed mode. In the same edge `ready` is set to 1 and the state becomes DONE.
- Divide by zero is RISC-V compatible: `quo` = all ones, `rem` = `a` unchanged, `dbz`=1.
- Signed overflow (most-negative ÷ −1): `quo` = most-negative, `rem` = 0, `dbz`=0. This result comes from the normal iteration with no special case.
- `start` while BUSY is ignored; the operation in progress is not disturbed.
- `a`/`b` may change freely after the accepting edge.

## Timing
- Accept edge E0 (`start`=1, not BUSY). `ready` reads 0 after E0.
- Nonzero divisor: results and `ready`=1 are visible after edge E0+WIDTH, which is 32 cycles for the default. The unit can accept a new `start` in that same DONE cycle.
- Zero divisor: `ready`=1 and `dbz`=1 are visible after edge E0+1.
- Back-to-back: `start` held high in DONE is accepted on the next edge. `ready` falls at that edge, so each result is visible for at least one cycle.
- Reset dominates `start` in the same cycle.

## Structure
- Shared package `div_pkg` holds:
  - the `div_state_t` enum (IDLE, BUSY, DONE);
  - the `DIV_WIDTH` default constant;
  - the `CNT_W` = $clog2(WIDTH) constant.
- Sub-module `div_step` is combinational. It takes the partial remainder, the incoming dividend bit and the divisor magnitude, and returns the next partial remainder and the quotient bit. It is kept separate so it can be unit-tested and later replicated for a radix-4 version.
- Sign handling (magnitude in, negate out) stays in the top level.

## Test plan
- Unsigned, `a`=12, `b`=7, one-cycle `start` → exactly 32 cycles later `ready`=1, `quo`=1, `rem`=5, `dbz`=0.
- `a`=100, `b`=0 → after 1 cycle `ready`=1, `dbz`=1, `quo`=0xFFFFFFFF, `rem`=100.
- With `SIGNED`=1:
  - `a`=−7, `b`=2 → `quo`=−3, `rem`=−1.
  - `a`=0x80000000, `b`=0xFFFFFFFF → `quo`=0x80000000, `rem`=0.
- `start` with `a`=1000, `b`=3, then a second `start` with `a`=9, `b`=9 at cycle 10 → the second request is ignored; the result is `quo`=333, `rem`=1.
- `_rst`=0 at cycle 15 of a running divide → after that edge `ready`=0 and `quo`=`rem`=0; a new `start` then completes normally.
- Back-to-back: `start` reasserted in the DONE cycle with `a`=0xFFFFFFFF, `b`=0x10000 → the first result is visible for one cycle, then `ready` drops. 32 cycles later `quo`=0xFFFF and `rem`=0xFFFF.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] div_i,
    output logic [W:0]   rem_o,
    output logic         qbit_o
);

    logic [W+1:0] shifted;
    logic [W+1:0] diff;

    // The partial remainder stays below the divisor, so W+2 bits hold the sign of the trial.
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {2'b00, div_i};
    assign qbit_o  = ~diff[W+1];
    assign rem_o   = qbit_o ? diff[W:0] : shifted[W:0];

endmodule

// File: rtl/seq_div.sv
// Radix-2 restoring divider, one quotient bit per clock, start/ready handshake.
module seq_div
    import div_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             ready,
    output logic             dbz
);

    localparam int CNT_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam bit SGN      = (SIGNED != 0);

    div_state_t          state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]      part_q, part_d;
    logic [WIDTH-1:0]    shq_q, shq_d;
    logic [WIDTH-1:0]    bmag_q, bmag_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;
    logic [WIDTH-1:0]    quo_q, quo_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic                ready_q, ready_d;
    logic                dbz_q, dbz_d;

    logic [WIDTH:0]      step_rem;
    logic                step_bit;
    logic                a_neg, b_neg;
    logic [WIDTH-1:0]    a_mag, b_mag;
    logic [WIDTH-1:0]    q_fin, r_fin;

    div_step #(.W(WIDTH)) u_step (
        .rem_i  (part_q),
        .bit_i  (shq_q[WIDTH-1]),
        .div_i  (bmag_q),
        .rem_o  (step_rem),
        .qbit_o (step_bit)
    );

    // Magnitudes are unsigned, so the most-negative value maps to 2^(WIDTH-1) correctly.
    assign a_neg = SGN & a[WIDTH-1];
    assign b_neg = SGN & b[WIDTH-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;
    assign q_fin = {shq_q[WIDTH-2:0], step_bit};
    assign r_fin = step_rem[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        shq_d   = shq_q;
        bmag_d  = bmag_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        ready_d = ready_q;
        dbz_d   = dbz_q;
        case (state_q)
            BUSY: begin
                part_d = step_rem;
                shq_d  = q_fin;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_BITS'(WIDTH - 1)) begin
                    quo_d   = qneg_q ? (~q_fin + 1'b1) : q_fin;
                    rem_d   = rneg_q ? (~r_fin + 1'b1) : r_fin;
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                if (start) begin
                    if (b == '0) begin
                        quo_d   = '1;
                        rem_d   = a;
                        ready_d = 1'b1;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        part_d  = '0;
                        shq_d   = a_mag;
                        bmag_d  = b_mag;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        cnt_d   = '0;
                        ready_d = 1'b0;
                        dbz_d   = 1'b0;
                        state_d = BUSY;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            part_q  <= '0;
            shq_q   <= '0;
            bmag_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            ready_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            shq_q   <= shq_d;
            bmag_q  <= bmag_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            ready_q <= ready_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quo   = quo_q;
    assign rem   = rem_q;
    assign ready = ready_q;
    assign dbz   = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Bench: unsigned and signed dividers driven in lockstep, checked against plain-arithmetic results.
module tb_seq_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] quo_u, rem_u, quo_s, rem_s;
    logic        rdy_u, dbz_u, rdy_s, dbz_s;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    seq_div #(.WIDTH(32), .SIGNED(0)) dut_u (
        .clk(clk), ._rst(rst_n), .start(start), .a(a), .b(b),
        .quo(quo_u), .rem(rem_u), .ready(rdy_u), .dbz(dbz_u)
    );

    seq_div #(.WIDTH(32), .SIGNED(1)) dut_s (
        .clk(clk), ._rst(rst_n), .start(start), .a(a), .b(b),
        .quo(quo_s), .rem(rem_s), .ready(rdy_s), .dbz(dbz_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V division semantics from ordinary integer arithmetic.
    task automatic model(input bit sgn, input logic [31:0] aa, input logic [31:0] bb,
                         output logic [31:0] q, output logic [31:0] r, output logic d);
        int sa, sb;
        sa = aa;
        sb = bb;
        d  = 1'b0;
        if (bb == 0) begin
            q = 32'hFFFF_FFFF;
            r = aa;
            d = 1'b1;
        end else if (!sgn) begin
            q = aa / bb;
            r = aa % bb;
        end else if (aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endtask

    task automatic check_results(input logic [31:0] aa, input logic [31:0] bb);
        logic [31:0] q, r;
        logic        d;
        model(1'b0, aa, bb, q, r, d);
        chk("u_ready", {31'd0, rdy_u}, 32'd1);
        chk("u_quo", quo_u, q);
        chk("u_rem", rem_u, r);
        chk("u_dbz", {31'd0, dbz_u}, {31'd0, d});
        model(1'b1, aa, bb, q, r, d);
        chk("s_ready", {31'd0, rdy_s}, 32'd1);
        chk("s_quo", quo_s, q);
        chk("s_rem", rem_s, r);
        chk("s_dbz", {31'd0, dbz_s}, {31'd0, d});
    endtask

    // Caller is just after a rising edge; returns just after the edge where results appear.
    task automatic do_op(input logic [31:0] aa, input logic [31:0] bb);
        a = aa;
        b = bb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        if (bb == 0) begin
            check_results(aa, bb);
        end else begin
            chk("ready_low_e0", {31'd0, rdy_u | rdy_s}, 32'd0);
            repeat (31) @(posedge clk);
            #1;
            chk("ready_low_e31", {31'd0, rdy_u | rdy_s}, 32'd0);
            @(posedge clk);
            #1;
            check_results(aa, bb);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_quo", quo_u | quo_s, 32'd0);
        chk("rst_rem", rem_u | rem_s, 32'd0);
        chk("rst_flags", {30'd0, rdy_u | rdy_s, dbz_u | dbz_s}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op(32'd12, 32'd7);
        do_op(32'd100, 32'd0);
        do_op(32'hFFFF_FFF9, 32'd2);
        do_op(32'h8000_0000, 32'hFFFF_FFFF);

        // Back-to-back: a new start in the DONE cycle of the previous divide.
        do_op(32'hFFFF_FFFF, 32'h0001_0000);
        do_op(32'd7, 32'hFFFF_FFFF);

        // A start while busy must not disturb the running divide.
        a = 32'd1000;
        b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        a = 32'd9;
        b = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        chk("busy_ready_low", {31'd0, rdy_u | rdy_s}, 32'd0);
        @(posedge clk);
        #1;
        check_results(32'd1000, 32'd3);

        // Reset in the middle of a divide discards it.
        a = 32'd5000;
        b = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("midrst_quo", quo_u | quo_s, 32'd0);
        chk("midrst_rem", rem_u | rem_s, 32'd0);
        chk("midrst_flags", {30'd0, rdy_u | rdy_s, dbz_u | dbz_s}, 32'd0);
        rst_n = 1'b1;
        do_op(32'd5000, 32'd7);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 17);
                2: rb = -$urandom_range(1, 17);
                3: begin ra = 32'h8000_0000; rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd3; end
                4: rb = rb >> $urandom_range(0, 31);
                default: ;
            endcase
            do_op(ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
